// File: rtl/bcd_pkg.sv
// Shared constants for the BCD tick counter: active-low 7-segment codes
// (bit0=a .. bit6=g, bit7=dp, dp always off), the blank pattern, the largest
// BCD digit value and a digit clamp helper used on parallel load.
package bcd_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Non-BCD nibbles (A..F) are treated as 9 so the counter never holds an
    // illegal digit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        if (d > BCD_MAX) begin
            return BCD_MAX;
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Ports:
//   i_digit : BCD digit 0..9
//   i_blank : 1 forces all segments off
//   o_seg   : active-low segments, bit0=a .. bit6=g, bit7=dp (always off)
module bcd7seg
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    // Digit lookup; codes outside 0..9 cannot occur after load clamping and
    // decode to blank.
    always_comb begin
        o_seg = SEG_BLANK;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD event counter with tick prescaler and 7-segment outputs.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   en              : run enable (freezes prescaler and counter when 0)
//   up              : 1 = count up, 0 = count down
//   wrap_en         : 1 = wrap at limit, 0 = saturate
//   clr, load       : synchronous clear / parallel load (clr wins)
//   load_val        : BCD load value, digit 0 in [3:0]
//   bcd             : current count, digit 0 in [3:0]
//   seg             : active-low segments per digit
//   tick            : one-cycle prescaler expiry pulse
//   carry           : one-cycle pulse on wrap, coincident with the new count
//   at_limit        : count is all-9s (up) or all-0s (down)
module bcd_tick_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 50000000,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  wrap_en,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [8*DIGITS-1:0]   seg,
    output logic                  tick,
    output logic                  carry,
    output logic                  at_limit
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]         PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [4*DIGITS-1:0]   ALL_NINES = {DIGITS{BCD_MAX}};

    logic [PW-1:0]       r_presc;
    logic                r_tick;
    logic                r_carry;
    logic [4*DIGITS-1:0] r_bcd;

    logic [4*DIGITS-1:0] w_next;
    logic                w_ripple;
    logic [4*DIGITS-1:0] w_load;
    logic [DIGITS-1:0]   w_blank;
    logic                w_seen_nz;

    // Ripple BCD +/-1; w_ripple left high means every digit rolled over,
    // i.e. the count was at its limit for the current direction.
    always_comb begin
        w_next   = r_bcd;
        w_ripple = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_ripple) begin
                if (up) begin
                    if (r_bcd[4*i +: 4] == BCD_MAX) begin
                        w_next[4*i +: 4] = 4'd0;
                    end else begin
                        w_next[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                        w_ripple         = 1'b0;
                    end
                end else begin
                    if (r_bcd[4*i +: 4] == 4'd0) begin
                        w_next[4*i +: 4] = BCD_MAX;
                    end else begin
                        w_next[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
                        w_ripple         = 1'b0;
                    end
                end
            end else begin
                w_next[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
    end

    // Load value with every nibble clamped to a legal BCD digit.
    always_comb begin
        w_load = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_load[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
        end
    end

    // Leading-zero blanking: scan from the most significant digit down;
    // digit 0 is always shown.
    always_comb begin
        w_blank   = '0;
        w_seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_seen_nz = 1'b1;
            end else begin
                w_seen_nz = w_seen_nz;
            end
            w_blank[i] = (BLANK_LZ != 0) && (i != 0) && !w_seen_nz;
        end
    end

    // Prescaler, tick pulse, count register and carry pulse.
    // The step uses the tick registered in the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
            r_bcd   <= '0;
        end else if (clr) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
            r_bcd   <= '0;
        end else if (load) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
            r_bcd   <= w_load;
        end else if (!en) begin
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            if (r_presc == PRE_LAST) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_presc <= r_presc + PW'(1);
                r_tick  <= 1'b0;
            end
            r_carry <= 1'b0;
            if (r_tick) begin
                if (!w_ripple) begin
                    r_bcd <= w_next;
                end else if (wrap_en) begin
                    r_bcd   <= w_next;
                    r_carry <= 1'b1;
                end else begin
                    r_bcd <= r_bcd;
                end
            end else begin
                r_bcd <= r_bcd;
            end
        end
    end

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_seg
            bcd7seg u_seg (
                .i_digit (r_bcd[4*g +: 4]),
                .i_blank (w_blank[g]),
                .o_seg   (seg[8*g +: 8])
            );
        end
    endgenerate

    assign bcd      = r_bcd;
    assign tick     = r_tick;
    assign carry    = r_carry;
    assign at_limit = up ? (r_bcd == ALL_NINES) : (r_bcd == '0);

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench for bcd_tick_counter. Two instances run in lock-step:
// A = 2 digits, prescale 4, no blanking; B = 4 digits, prescale 3, blanking.
// The reference model keeps the count as a plain decimal integer.
module tb_bcd_tick_counter;

    localparam int DA = 2;
    localparam int PA = 4;
    localparam int DB = 4;
    localparam int PB = 3;

    localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, up, wrap_en, clr, load;
    logic [7:0]  lv_a;
    logic [15:0] lv_b;

    logic [7:0]  a_bcd;
    logic [15:0] a_seg;
    logic        a_tick, a_carry, a_lim;
    logic [15:0] b_bcd;
    logic [31:0] b_seg;
    logic        b_tick, b_carry, b_lim;

    bcd_tick_counter #(.DIGITS(DA), .PRESCALE(PA), .BLANK_LZ(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .wrap_en(wrap_en),
        .clr(clr), .load(load), .load_val(lv_a),
        .bcd(a_bcd), .seg(a_seg), .tick(a_tick), .carry(a_carry), .at_limit(a_lim)
    );

    bcd_tick_counter #(.DIGITS(DB), .PRESCALE(PB), .BLANK_LZ(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .wrap_en(wrap_en),
        .clr(clr), .load(load), .load_val(lv_b),
        .bcd(b_bcd), .seg(b_seg), .tick(b_tick), .carry(b_carry), .at_limit(b_lim)
    );

    typedef struct packed {
        logic [7:0]  a_bcd;
        logic [15:0] a_seg;
        logic        a_tick;
        logic        a_carry;
        logic        a_lim;
        logic [15:0] b_bcd;
        logic [31:0] b_seg;
        logic        b_tick;
        logic        b_carry;
        logic        b_lim;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state per instance (0 = A, 1 = B)
    int m_val   [2];
    int m_presc [2];
    bit m_tick  [2];
    bit m_carry [2];
    int m_dig   [2] = '{DA, DB};
    int m_pre   [2] = '{PA, PB};

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int to_dec(input logic [15:0] raw, input int d);
        int v = 0;
        int nib;
        for (int i = 0; i < d; i++) begin
            nib = int'(raw[4*i +: 4]);
            if (nib > 9) nib = 9;
            v = v + nib * p10(i);
        end
        return v;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int d);
        logic [31:0] r = '0;
        for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
        return r;
    endfunction

    function automatic logic [63:0] to_seg(input int v, input int d, input bit blz);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++) begin
            if (blz && i > 0 && v < p10(i)) r[8*i +: 8] = 8'hFF;
            else                            r[8*i +: 8] = SEG_TAB[(v / p10(i)) % 10];
        end
        return r;
    endfunction

    task automatic model_step(input int k, input bit r_, input bit e_, input bit u_,
                              input bit w_, input bit c_, input bit l_, input logic [15:0] raw);
        int  maxv = p10(m_dig[k]) - 1;
        bit  old_tick = m_tick[k];
        if (r_ || c_) begin
            m_val[k] = 0; m_presc[k] = 0; m_tick[k] = 0; m_carry[k] = 0;
        end else if (l_) begin
            m_val[k] = to_dec(raw, m_dig[k]); m_presc[k] = 0; m_tick[k] = 0; m_carry[k] = 0;
        end else if (!e_) begin
            m_tick[k] = 0; m_carry[k] = 0;
        end else begin
            m_carry[k] = 0;
            if (old_tick) begin
                if (u_) begin
                    if (m_val[k] < maxv) m_val[k] = m_val[k] + 1;
                    else if (w_) begin m_val[k] = 0; m_carry[k] = 1; end
                end else begin
                    if (m_val[k] > 0) m_val[k] = m_val[k] - 1;
                    else if (w_) begin m_val[k] = maxv; m_carry[k] = 1; end
                end
            end
            if (m_presc[k] == m_pre[k] - 1) begin
                m_presc[k] = 0; m_tick[k] = 1;
            end else begin
                m_presc[k] = m_presc[k] + 1; m_tick[k] = 0;
            end
        end
    endtask

    // Apply one cycle of inputs at the falling edge and queue the expected
    // outputs seen after the following rising edge.
    task automatic cycle(input bit r_, input bit e_, input bit u_, input bit w_,
                         input bit c_, input bit l_, input logic [15:0] lb);
        exp_t e;
        logic [31:0] bt;
        logic [63:0] st;
        @(negedge clk);
        rst = r_; en = e_; up = u_; wrap_en = w_; clr = c_; load = l_;
        lv_a = lb[7:0]; lv_b = lb;
        model_step(0, r_, e_, u_, w_, c_, l_, {8'h00, lb[7:0]});
        model_step(1, r_, e_, u_, w_, c_, l_, lb);
        bt = to_bcd(m_val[0], DA);      e.a_bcd = bt[7:0];
        st = to_seg(m_val[0], DA, 1'b0); e.a_seg = st[15:0];
        e.a_tick  = m_tick[0];
        e.a_carry = m_carry[0];
        e.a_lim   = u_ ? (m_val[0] == p10(DA) - 1) : (m_val[0] == 0);
        bt = to_bcd(m_val[1], DB);      e.b_bcd = bt[15:0];
        st = to_seg(m_val[1], DB, 1'b1); e.b_seg = st[31:0];
        e.b_tick  = m_tick[1];
        e.b_carry = m_carry[1];
        e.b_lim   = u_ ? (m_val[1] == p10(DB) - 1) : (m_val[1] == 0);
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input bit e_, input bit u_, input bit w_);
        for (int i = 0; i < n; i++) cycle(1'b0, e_, u_, w_, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per cycle, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("a_bcd",   64'(a_bcd),   64'(e.a_bcd));
                chk("a_seg",   64'(a_seg),   64'(e.a_seg));
                chk("a_tick",  64'(a_tick),  64'(e.a_tick));
                chk("a_carry", 64'(a_carry), 64'(e.a_carry));
                chk("a_lim",   64'(a_lim),   64'(e.a_lim));
                chk("b_bcd",   64'(b_bcd),   64'(e.b_bcd));
                chk("b_seg",   64'(b_seg),   64'(e.b_seg));
                chk("b_tick",  64'(b_tick),  64'(e.b_tick));
                chk("b_carry", 64'(b_carry), 64'(e.b_carry));
                chk("b_lim",   64'(b_lim),   64'(e.b_lim));
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        bit          r_u, r_w;
        logic [15:0] lb;
        int          sel;
        rst = 1'b1; en = 1'b0; up = 1'b1; wrap_en = 1'b1; clr = 1'b0; load = 1'b0;
        lv_a = 8'h00; lv_b = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_presc[k] = 0; m_tick[k] = 0; m_carry[k] = 0;
        end

        // reset, then count up from zero
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        run(12, 1'b1, 1'b1, 1'b1);

        // up wrap
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h9998);
        run(12, 1'b1, 1'b1, 1'b1);

        // saturate down
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001);
        run(16, 1'b1, 1'b0, 1'b0);

        // clr beats load, then load with clamping
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5555);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFAFA);
        run(4, 1'b1, 1'b1, 1'b0);

        // enable freeze two cycles before a tick
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0010);
        run(2, 1'b1, 1'b1, 1'b1);
        run(10, 1'b0, 1'b1, 1'b1);
        run(8, 1'b1, 1'b1, 1'b1);

        // blanking patterns
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0007);
        run(2, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
        run(2, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0300);
        run(2, 1'b0, 1'b1, 1'b1);

        // reset mid-count
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h4242);
        run(5, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        run(10, 1'b1, 1'b1, 1'b1);

        // randomized traffic
        r_u = 1'b1; r_w = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) r_u = ~r_u;
            if ($urandom_range(0, 49) == 0) r_w = ~r_w;
            for (int d = 0; d < 4; d++) begin
                sel = $urandom_range(0, 7);
                if (sel == 0)      lb[4*d +: 4] = 4'd0;
                else if (sel == 1) lb[4*d +: 4] = 4'd9;
                else if (sel == 2) lb[4*d +: 4] = 4'($urandom_range(10, 15));
                else               lb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, r_u, r_w,
                  $urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, lb);
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
Parametrised multi-digit BCD event counter with a built-in tick prescaler and per-digit 7-segment outputs. It is the next generation of the fixed 8-bit incrementer, the 3-bit decrementer, the 1 s timer and the %10 and /10 display split. It adds:
- runtime up/down counting;
- synchronous clear and parallel load;
- wrap or saturate modes;
- carry/borrow pulses for cascading;
- optional leading-zero blanking.
It sits between the board clock and the seg display outputs in top.

Parameters:
DIGITS, 2, number of BCD digits (1..8)
PRESCALE, 50000000, clk cycles per count tick (>=1; 1 = step every enabled cycle)
BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 is never blanked)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  run enable; 0 freezes prescaler and counter
up  input  1  count direction: 1 = up, 0 = down
wrap_en  input  1  1 = wrap at limit, 0 = saturate at limit
clr  input  1  synchronous clear
load  input  1  synchronous parallel load
load_val  input  4*DIGITS  BCD load value, digit 0 in [3:0]
bcd  output  4*DIGITS  current count, digit 0 in [3:0]
seg  output  8*DIGITS  active-low segments per digit, bit0=a .. bit6=g, bit7=dp
tick  output  1  one-cycle pulse when the prescaler expires
carry  output  1  one-cycle pulse on wrap (9..9->0..0 up, or 0..0->9..9 down)
at_limit  output  1  count equals all-9s (up) or all-0s (down)

Behaviour:
- Reset (async, rst=1):
  - prescaler=0, bcd=0, tick=0, carry=0.
  - seg shows "0" on digit 0, 8'hC0.
  - Other digits show 8'hC0, or 8'hFF if BLANK_LZ=1.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1.
  - In the cycle it equals PRESCALE-1 it returns to 0 and tick is registered high for the next cycle.
  - en=0 holds the prescaler and forces tick=0.
- Priority per cycle: clr > load > step.
  - clr=1: bcd<=0, prescaler<=0, tick<=0, carry<=0. Applies regardless of en.
  - load=1 (clr=0): bcd<=load_val with each nibble >9 clamped to 9, prescaler<=0, carry<=0. Applies regardless of en.
- Step: occurs in the cycle after tick=1, when en=1 and neither clr nor load is active.
  - Up: digit 0 increments; a digit at 9 becomes 0 and ripples +1 to the next digit.
  - Down: mirror behaviour with borrow, a digit at 0 becomes 9.
- Limit handling:
  - At the limit with wrap_en=1: bcd wraps, and carry is registered high for exactly one cycle, coincident with the new bcd value.
  - At the limit with wrap_en=0: bcd holds and carry stays 0.
- Latency:
  - bcd and carry update 1 cycle after the tick cycle.
  - seg and at_limit are combinational from bcd (0 extra latency).
- A direction change takes effect at the next step; no state is lost.
- Segment codes (active-low, dp always 1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - With BLANK_LZ=1, any zero digit above the highest non-zero digit outputs FF.
- Reset asserted mid-count aborts immediately. After rst falls, counting resumes from 0 with a full PRESCALE period before the first tick.

Decomposition:
- Package bcd_pkg:
  - SEG_* localparams for the 10 digit codes and SEG_BLANK=8'hFF;
  - BCD_MAX=4'd9.
- One sub-module, bcd7seg: a combinational nibble-to-segment decoder with a blank input, instantiated DIGITS times via generate.
- The prescaler and the ripple BCD adder stay in the top-level block.

Test Plan:
1. Reset and prescale (DIGITS=2, PRESCALE=4, BLANK_LZ=0): pulse rst, en=1, up=1 -> tick every 4th cycle; bcd 00->01->02; seg[7:0]=F9 after the first step, seg[15:8]=C0.
2. Up wrap: load_val=8'h98, wrap_en=1, two ticks -> bcd 99 with at_limit=1, then 00 with carry=1 for one cycle.
3. Saturate: load 8'h01, up=0, wrap_en=0, three ticks -> bcd 00 then holds at 00; carry never asserts; at_limit=1.
4. Priority and clamp:
   - clr=1 and load=1 together with load_val=8'h55 -> bcd=00.
   - Next cycle, load only with load_val=8'hFA -> bcd=99.
5. Enable freeze: drop en two cycles before an expected tick for 10 cycles -> no tick and bcd unchanged; after en returns, tick arrives after the remaining 2 cycles.
6. Blanking (BLANK_LZ=1, DIGITS=4):
   - load 16'h0007 -> seg = FF,FF,FF,F8 (msd..lsd).
   - load 0 -> FF,FF,FF,C0.
